bp_be_fe_cmd_adapter: RTL and testbench

- Back-end-side peer of the front end's command/queue interface.
- Buffers BE-generated FE commands (redirects, fills, fences, attaboys) and issues them to the FE over a valid/yumi handshake.
- Absorbs the FE's fetch/exception queue into a local FIFO for BE issue.
- Flushes wrong-path fetches when a non-attaboy command is consumed, and tracks whether the FE is parked waiting for a restart command.

---
 rtl/bp_be_fe_cmd_adapter_if.sv | 44 ++++
 rtl/bp_be_fe_cmd_adapter.sv | 104 ++++++++++
 tb/tb_bp_be_fe_cmd_adapter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bp_be_fe_cmd_adapter_if.sv
// Back-end <-> front-end command/queue bundle.
// Signal names carry the adapter's direction (_i into the adapter, _o out).
//   master : adapter view (drives *_o)
//   slave  : peer/driver view (drives *_i)
//   cmd_*          BE command push side
//   fe_cmd_*       command issue to FE (valid/yumi)
//   fe_queue_*     FE fetch/exception queue into adapter (valid/ready)
//   fetch_*        buffered fetch entries to BE (valid/yumi)
//   fe_waiting_o   FE parked, needs a non-attaboy command
interface bp_be_fe_cmd_adapter_if #(
    parameter int fe_cmd_width_p   = 64,
    parameter int fe_queue_width_p = 128
);
    logic [fe_cmd_width_p-1:0]   cmd_i;
    logic                        cmd_attaboy_i;
    logic                        cmd_v_i;
    logic                        cmd_ready_o;
    logic [fe_cmd_width_p-1:0]   fe_cmd_o;
    logic                        fe_cmd_v_o;
    logic                        fe_cmd_yumi_i;
    logic [fe_queue_width_p-1:0] fe_queue_i;
    logic                        fe_queue_exception_i;
    logic                        fe_queue_v_i;
    logic                        fe_queue_ready_o;
    logic [fe_queue_width_p-1:0] fetch_o;
    logic                        fetch_exception_o;
    logic                        fetch_v_o;
    logic                        fetch_yumi_i;
    logic                        fe_waiting_o;

    modport master (
        input  cmd_i, cmd_attaboy_i, cmd_v_i, fe_cmd_yumi_i,
               fe_queue_i, fe_queue_exception_i, fe_queue_v_i, fetch_yumi_i,
        output cmd_ready_o, fe_cmd_o, fe_cmd_v_o, fe_queue_ready_o,
               fetch_o, fetch_exception_o, fetch_v_o, fe_waiting_o
    );

    modport slave (
        output cmd_i, cmd_attaboy_i, cmd_v_i, fe_cmd_yumi_i,
               fe_queue_i, fe_queue_exception_i, fe_queue_v_i, fetch_yumi_i,
        input  cmd_ready_o, fe_cmd_o, fe_cmd_v_o, fe_queue_ready_o,
               fetch_o, fetch_exception_o, fetch_v_o, fe_waiting_o
    );
endinterface

// File: rtl/bp_be_fe_cmd_adapter.sv
// BE-side peer of the FE command/queue interface.
//   - Command FIFO: buffers BE commands {attaboy, cmd}, issues to FE (valid/yumi).
//   - Fetch FIFO: absorbs FE queue entries {exception, entry}, issues to BE.
//   - Consuming a non-attaboy command flushes wrong-path fetches and restarts FE.
// Ports: clk_i, reset_n_i (async active-low), bus (master modport, see _if).
module bp_be_fe_cmd_adapter #(
    parameter int fe_cmd_width_p   = 64,
    parameter int fe_queue_width_p = 128,
    parameter int cmd_els_p        = 4,
    parameter int fetch_els_p      = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_be_fe_cmd_adapter_if.master bus
);
    localparam int CA_W = $clog2(cmd_els_p);
    localparam int CC_W = CA_W + 1;
    localparam int FA_W = $clog2(fetch_els_p);
    localparam int FC_W = FA_W + 1;

    // Payload storage, not reset
    logic [fe_cmd_width_p:0]   cmd_mem   [cmd_els_p];
    logic [fe_queue_width_p:0] fetch_mem [fetch_els_p];

    logic [CA_W-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [CC_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [FA_W-1:0] fetch_wptr_q, fetch_wptr_d, fetch_rptr_q, fetch_rptr_d;
    logic [FC_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic            waiting_q, waiting_d;

    logic cmd_full, cmd_empty, cmd_push, cmd_pop, head_attaboy;
    logic fetch_full, fetch_empty, fetch_push, fetch_pop, flush;

    assign cmd_full    = (cmd_cnt_q == CC_W'(cmd_els_p));
    assign cmd_empty   = (cmd_cnt_q == '0);
    assign fetch_full  = (fetch_cnt_q == FC_W'(fetch_els_p));
    assign fetch_empty = (fetch_cnt_q == '0);

    assign {head_attaboy, bus.fe_cmd_o}          = cmd_mem[cmd_rptr_q];
    assign {bus.fetch_exception_o, bus.fetch_o} = fetch_mem[fetch_rptr_q];

    assign bus.cmd_ready_o  = ~cmd_full;
    assign bus.fe_cmd_v_o   = ~cmd_empty;
    assign bus.fetch_v_o    = ~fetch_empty;
    assign bus.fe_waiting_o = waiting_q;
    // FE never enqueues while a non-attaboy command is presented to it
    assign bus.fe_queue_ready_o = ~fetch_full & ~waiting_q & ~(bus.fe_cmd_v_o & ~head_attaboy);

    assign cmd_push   = bus.cmd_v_i & ~cmd_full;
    assign cmd_pop    = bus.fe_cmd_yumi_i & ~cmd_empty;
    assign flush      = cmd_pop & ~head_attaboy;
    assign fetch_push = bus.fe_queue_v_i & bus.fe_queue_ready_o;
    // flush discards everything, so a same-cycle BE pop is moot
    assign fetch_pop  = bus.fetch_yumi_i & ~fetch_empty & ~flush;

    always_comb begin
        cmd_wptr_d   = cmd_wptr_q;
        cmd_rptr_d   = cmd_rptr_q;
        fetch_wptr_d = fetch_wptr_q;
        fetch_rptr_d = fetch_rptr_q;
        if (cmd_push)   cmd_wptr_d   = cmd_wptr_q + 1'b1;
        if (cmd_pop)    cmd_rptr_d   = cmd_rptr_q + 1'b1;
        if (fetch_push) fetch_wptr_d = fetch_wptr_q + 1'b1;
        if (fetch_pop)  fetch_rptr_d = fetch_rptr_q + 1'b1;
        cmd_cnt_d   = cmd_cnt_q + {{CA_W{1'b0}}, cmd_push} - {{CA_W{1'b0}}, cmd_pop};
        fetch_cnt_d = fetch_cnt_q + {{FA_W{1'b0}}, fetch_push} - {{FA_W{1'b0}}, fetch_pop};
        if (flush) begin
            fetch_wptr_d = '0;
            fetch_rptr_d = '0;
            fetch_cnt_d  = '0;
        end
        waiting_d = waiting_q;
        if (fetch_push & bus.fe_queue_exception_i) waiting_d = 1'b1;
        if (flush)                                  waiting_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_wptr_q   <= '0;
            cmd_rptr_q   <= '0;
            cmd_cnt_q    <= '0;
            fetch_wptr_q <= '0;
            fetch_rptr_q <= '0;
            fetch_cnt_q  <= '0;
            waiting_q    <= 1'b1;
        end else begin
            cmd_wptr_q   <= cmd_wptr_d;
            cmd_rptr_q   <= cmd_rptr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            fetch_wptr_q <= fetch_wptr_d;
            fetch_rptr_q <= fetch_rptr_d;
            fetch_cnt_q  <= fetch_cnt_d;
            waiting_q    <= waiting_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push)   cmd_mem[cmd_wptr_q]     <= {bus.cmd_attaboy_i, bus.cmd_i};
        if (fetch_push) fetch_mem[fetch_wptr_q] <= {bus.fe_queue_exception_i, bus.fe_queue_i};
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.fe_cmd_yumi_i |-> bus.fe_cmd_v_o);
endmodule

// File: tb/tb_bp_be_fe_cmd_adapter.sv
module tb_bp_be_fe_cmd_adapter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bp_be_fe_cmd_adapter_if #(.fe_cmd_width_p(64), .fe_queue_width_p(128)) bus ();

    bp_be_fe_cmd_adapter #(
        .fe_cmd_width_p(64), .fe_queue_width_p(128), .cmd_els_p(4), .fetch_els_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [63:0] c, input logic ab);
        bus.cmd_i = c; bus.cmd_attaboy_i = ab; bus.cmd_v_i = 1'b1;
        tick();
        bus.cmd_v_i = 1'b0;
    endtask

    task automatic push_fq(input logic [127:0] e, input logic exc);
        bus.fe_queue_i = e; bus.fe_queue_exception_i = exc; bus.fe_queue_v_i = 1'b1;
        tick();
        bus.fe_queue_v_i = 1'b0; bus.fe_queue_exception_i = 1'b0;
    endtask

    task automatic pop_fetch(input string tag, input logic [127:0] exp);
        chk({tag, "_v"}, 128'(bus.fetch_v_o), 128'd1);
        chk(tag, bus.fetch_o, exp);
        bus.fetch_yumi_i = 1'b1;
        tick();
        bus.fetch_yumi_i = 1'b0;
    endtask

    task automatic pop_cmd(input string tag, input logic [63:0] exp);
        chk({tag, "_v"}, 128'(bus.fe_cmd_v_o), 128'd1);
        chk(tag, 128'(bus.fe_cmd_o), 128'(exp));
        bus.fe_cmd_yumi_i = 1'b1;
        tick();
        bus.fe_cmd_yumi_i = 1'b0;
    endtask

    initial begin
        bus.cmd_i = '0; bus.cmd_attaboy_i = 1'b0; bus.cmd_v_i = 1'b0;
        bus.fe_cmd_yumi_i = 1'b0;
        bus.fe_queue_i = '0; bus.fe_queue_exception_i = 1'b0; bus.fe_queue_v_i = 1'b0;
        bus.fetch_yumi_i = 1'b0;

        // reset, released between edges
        #12 rst_n = 1'b1;
        tick();
        chk("rst_cmd_v",   128'(bus.fe_cmd_v_o), 128'd0);
        chk("rst_fetch_v", 128'(bus.fetch_v_o), 128'd0);
        chk("rst_cmd_rdy", 128'(bus.cmd_ready_o), 128'd1);
        chk("rst_wait",    128'(bus.fe_waiting_o), 128'd1);
        chk("rst_fq_rdy",  128'(bus.fe_queue_ready_o), 128'd0);

        // state_reset command restarts the FE; queue ignored while waiting
        bus.fe_queue_i = 128'hDEAD; bus.fe_queue_v_i = 1'b1;
        push_cmd(64'hA0, 1'b0);
        bus.fe_queue_v_i = 1'b0;
        chk("sr_cmd_v",  128'(bus.fe_cmd_v_o), 128'd1);
        chk("sr_fq_rdy", 128'(bus.fe_queue_ready_o), 128'd0);
        chk("sr_no_fq",  128'(bus.fetch_v_o), 128'd0);
        pop_cmd("sr_cmd", 64'hA0);
        chk("sr_wait",    128'(bus.fe_waiting_o), 128'd0);
        chk("sr_fq_rdy1", 128'(bus.fe_queue_ready_o), 128'd1);
        chk("sr_cmd_v0",  128'(bus.fe_cmd_v_o), 128'd0);

        // fill fetch FIFO, overflow attempt, drain in order
        for (int i = 0; i < 8; i++) push_fq(128'h100 + 128'(4 * i), 1'b0);
        chk("full_fq_rdy", 128'(bus.fe_queue_ready_o), 128'd0);
        push_fq(128'h200, 1'b0);
        pop_fetch("fetch0", 128'h100);
        chk("after_pop_rdy", 128'(bus.fe_queue_ready_o), 128'd1);
        for (int i = 1; i < 8; i++) pop_fetch("fetchN", 128'h100 + 128'(4 * i));
        chk("drained", 128'(bus.fetch_v_o), 128'd0);

        // redirect consume flushes, beats same-cycle fetch yumi
        for (int i = 0; i < 3; i++) push_fq(128'h300 + 128'(i), 1'b0);
        push_cmd(64'hB1, 1'b0);
        chk("redir_fq_rdy", 128'(bus.fe_queue_ready_o), 128'd0);
        bus.fe_cmd_yumi_i = 1'b1; bus.fetch_yumi_i = 1'b1;
        tick();
        bus.fe_cmd_yumi_i = 1'b0; bus.fetch_yumi_i = 1'b0;
        chk("flush_fetch_v", 128'(bus.fetch_v_o), 128'd0);
        chk("flush_wait",    128'(bus.fe_waiting_o), 128'd0);
        push_fq(128'h333, 1'b0);
        pop_fetch("post_flush", 128'h333);
        chk("post_flush_empty", 128'(bus.fetch_v_o), 128'd0);

        // attaboy: no flush, queue stays open
        push_fq(128'h400, 1'b0);
        push_fq(128'h401, 1'b0);
        push_cmd(64'hC2, 1'b1);
        chk("ab_fq_rdy", 128'(bus.fe_queue_ready_o), 128'd1);
        bus.fe_cmd_yumi_i = 1'b1;
        push_fq(128'h402, 1'b0);
        bus.fe_cmd_yumi_i = 1'b0;
        chk("ab_cmd_v0", 128'(bus.fe_cmd_v_o), 128'd0);
        chk("ab_wait",   128'(bus.fe_waiting_o), 128'd0);
        pop_fetch("ab_f0", 128'h400);
        pop_fetch("ab_f1", 128'h401);
        pop_fetch("ab_f2", 128'h402);
        chk("ab_empty", 128'(bus.fetch_v_o), 128'd0);

        // exception parks the FE
        push_fq(128'h500, 1'b1);
        chk("exc_wait",   128'(bus.fe_waiting_o), 128'd1);
        chk("exc_fq_rdy", 128'(bus.fe_queue_ready_o), 128'd0);
        push_fq(128'h501, 1'b0);
        chk("exc_flag", 128'(bus.fetch_exception_o), 128'd1);
        pop_fetch("exc_entry", 128'h500);
        chk("exc_only_one", 128'(bus.fetch_v_o), 128'd0);

        // command FIFO full, 5th rejected
        for (int i = 0; i < 4; i++) push_cmd(64'hD0 + 64'(i), 1'b1);
        chk("cmd_full_rdy", 128'(bus.cmd_ready_o), 128'd0);
        push_cmd(64'hD4, 1'b1);
        for (int i = 0; i < 4; i++) pop_cmd("cmd_fifo", 64'hD0 + 64'(i));
        chk("cmd_5th_dropped", 128'(bus.fe_cmd_v_o), 128'd0);
        chk("ab_keeps_wait", 128'(bus.fe_waiting_o), 128'd1);

        // simultaneous push/pop at count 2
        push_cmd(64'hE0, 1'b1);
        push_cmd(64'hE1, 1'b1);
        bus.fe_cmd_yumi_i = 1'b1;
        push_cmd(64'hE2, 1'b1);
        bus.fe_cmd_yumi_i = 1'b0;
        chk("pp_rdy", 128'(bus.cmd_ready_o), 128'd1);
        pop_cmd("pp_e1", 64'hE1);
        pop_cmd("pp_e2", 64'hE2);
        chk("pp_empty", 128'(bus.fe_cmd_v_o), 128'd0);

        // asynchronous reset mid-operation
        push_cmd(64'hF0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_cmd_v", 128'(bus.fe_cmd_v_o), 128'd0);
        chk("async_wait",  128'(bus.fe_waiting_o), 128'd1);
        chk("async_rdy",   128'(bus.cmd_ready_o), 128'd1);
        #10 rst_n = 1'b1;
        tick();
        chk("async_after", 128'(bus.fe_cmd_v_o), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
